// File: rtl/fp_acc_pkg.sv
// Shared constants and float field layout for the fixed-point float accumulator.
package fp_acc_pkg;

    localparam int ACC_W   = 64;   // two's-complement accumulator width
    localparam int LSB_EXP = -30;  // weight of accumulator bit 0 is 2^LSB_EXP
    localparam int MAX_EXP = 32;   // samples with |x| >= 2^MAX_EXP overflow the input range
    localparam int FP_BIAS = 127;  // IEEE-754 single-precision exponent bias
    localparam int LATENCY = 4;    // enabled edges from sample capture to result

    // IEEE-754 single-precision field view
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

endpackage

// File: rtl/fp_accumulator_if.sv
// Sample/result bundle between the wrapper (master) and the accumulator (slave).
interface fp_accumulator_if;

    logic        en;   // clock enable for the whole accumulator
    logic        n;    // start a new accumulation with this sample
    logic [31:0] x;    // float sample
    logic [31:0] r;    // float running sum
    logic        xo;   // sample overflowed the input range
    logic        xu;   // sample underflowed the input range
    logic        ao;   // accumulator overflow, sticky within an accumulation

    modport master (output en, n, x, input  r, xo, xu, ao);
    modport slave  (input  en, n, x, output r, xo, xu, ao);

endinterface

// File: rtl/fp_acc_lzc.sv
// 64-bit leading-zero counter; an all-zero input reports 64.
module fp_acc_lzc (
    input  logic [63:0] i_val,
    output logic [6:0]  o_lz
);

    // Scan upward so the highest set bit makes the final assignment
    always_comb begin
        o_lz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (i_val[i]) begin
                o_lz = 7'(63 - i);
            end
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Pipelined float accumulator: align to a fixed-point grid, integer-add, normalize back to float.
module fp_accumulator
    import fp_acc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    fp_accumulator_if.slave  bus
);

    // Rebuild a float from sign, magnitude and its leading-zero count (mantissa truncated)
    function automatic logic [31:0] pack_float(input logic sign, input logic [ACC_W-1:0] mag,
                                               input logic [6:0] lz);
        logic [7:0] exp_f;
        if (mag == '0) begin
            return 32'h0000_0000;
        end
        exp_f = 8'(FP_BIAS + (ACC_W - 1) + LSB_EXP) - {1'b0, lz};
        return {sign, exp_f, 23'((mag << lz) >> (ACC_W - 24))};
    endfunction

    fp32_t                    w_x;
    logic signed [9:0]        w_exp_unb;
    logic signed [9:0]        w_sh;
    logic signed [9:0]        w_nsh;
    logic [ACC_W-1:0]         w_mag;
    logic signed [ACC_W-1:0]  w_aligned;
    logic                     w_xo;
    logic                     w_xu;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_ovf;
    logic [ACC_W-1:0]         w_acc_mag;
    logic [6:0]               w_lz;

    logic signed [ACC_W-1:0]  r_aligned_p1;
    logic                     r_n_p1;
    logic                     r_xo_p1;
    logic                     r_xu_p1;
    logic signed [ACC_W-1:0]  r_acc_p2;
    logic                     r_ao_p2;
    logic                     r_xo_p2;
    logic                     r_xu_p2;
    logic [ACC_W-1:0]         r_mag_p3;
    logic [6:0]               r_lz_p3;
    logic                     r_sign_p3;
    logic                     r_xo_p3;
    logic                     r_xu_p3;
    logic                     r_ao_p3;
    logic [31:0]              r_r_p4;
    logic                     r_xo_p4;
    logic                     r_xu_p4;
    logic                     r_ao_p4;

    assign w_x       = bus.x;
    assign w_exp_unb = $signed({2'b00, w_x.exp}) - 10'sd127;
    // Left shift that puts the 24-bit significand onto the 2^LSB_EXP grid
    assign w_sh      = w_exp_unb + 10'(-LSB_EXP - 23);
    assign w_nsh     = -w_sh;

    // S1 alignment: classify the sample and shift its significand onto the grid
    always_comb begin
        w_mag = '0;
        w_xo  = 1'b0;
        w_xu  = 1'b0;
        if (w_x.exp == 8'hFF) begin
            w_xo = 1'b1;
        end else if (w_x.exp == 8'h00) begin
            w_xu = (w_x.mant != '0);
        end else if (w_exp_unb >= 10'(MAX_EXP)) begin
            w_xo = 1'b1;
        end else if (w_exp_unb < 10'(LSB_EXP)) begin
            w_xu = 1'b1;
        end else if (w_sh >= 10'sd0) begin
            w_mag = {40'd0, 1'b1, w_x.mant} << w_sh[5:0];
        end else begin
            w_mag = {40'd0, 1'b1, w_x.mant} >> w_nsh[5:0];
        end
        w_aligned = w_x.sign ? -$signed(w_mag) : $signed(w_mag);
    end

    assign w_sum     = r_acc_p2 + r_aligned_p1;
    assign w_ovf     = (r_acc_p2[ACC_W-1] == r_aligned_p1[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc_p2[ACC_W-1]);
    // Negating the most negative value yields 2^63, which is correct when read as unsigned
    assign w_acc_mag = r_acc_p2[ACC_W-1] ? $unsigned(-r_acc_p2) : $unsigned(r_acc_p2);

    fp_acc_lzc u_lzc (
        .i_val (w_acc_mag),
        .o_lz  (w_lz)
    );

    // Four-stage pipeline; reset clears everything, en freezes everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_aligned_p1 <= '0;
            r_n_p1       <= 1'b0;
            r_xo_p1      <= 1'b0;
            r_xu_p1      <= 1'b0;
            r_acc_p2     <= '0;
            r_ao_p2      <= 1'b0;
            r_xo_p2      <= 1'b0;
            r_xu_p2      <= 1'b0;
            r_mag_p3     <= '0;
            r_lz_p3      <= '0;
            r_sign_p3    <= 1'b0;
            r_xo_p3      <= 1'b0;
            r_xu_p3      <= 1'b0;
            r_ao_p3      <= 1'b0;
            r_r_p4       <= '0;
            r_xo_p4      <= 1'b0;
            r_xu_p4      <= 1'b0;
            r_ao_p4      <= 1'b0;
        end else if (bus.en) begin
            // S1 -> aligned sample
            r_aligned_p1 <= w_aligned;
            r_n_p1       <= bus.n;
            r_xo_p1      <= w_xo;
            r_xu_p1      <= w_xu;
            // S2 -> accumulate; a load cannot overflow, so it clears the sticky flag
            if (r_n_p1) begin
                r_acc_p2 <= r_aligned_p1;
                r_ao_p2  <= 1'b0;
            end else begin
                r_acc_p2 <= w_sum;
                r_ao_p2  <= r_ao_p2 | w_ovf;
            end
            r_xo_p2      <= r_xo_p1;
            r_xu_p2      <= r_xu_p1;
            // S3 -> magnitude and leading-zero count
            r_mag_p3     <= w_acc_mag;
            r_lz_p3      <= w_lz;
            r_sign_p3    <= r_acc_p2[ACC_W-1];
            r_xo_p3      <= r_xo_p2;
            r_xu_p3      <= r_xu_p2;
            r_ao_p3      <= r_ao_p2;
            // S4 -> normalized float result
            r_r_p4       <= pack_float(r_sign_p3, r_mag_p3, r_lz_p3);
            r_xo_p4      <= r_xo_p3;
            r_xu_p4      <= r_xu_p3;
            r_ao_p4      <= r_ao_p3;
        end
    end

    assign bus.r  = r_r_p4;
    assign bus.xo = r_xo_p4;
    assign bus.xu = r_xu_p4;
    assign bus.ao = r_ao_p4;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with hand-computed float results.
module tb_fp_accumulator;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    fp_accumulator_if ifc ();

    fp_accumulator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge with the given inputs; returns 1 time unit after the edge
    task automatic tick(input logic en, input logic n, input logic [31:0] x);
        ifc.en = en;
        ifc.n  = n;
        ifc.x  = x;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic n, input logic [31:0] x);
        tick(1'b1, n, x);
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 32'h0000_0000);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] er, input logic eo,
                           input logic eu, input logic ea);
        chk({tag, ".r"},  ifc.r, er);
        chk({tag, ".xo"}, {31'd0, ifc.xo}, {31'd0, eo});
        chk({tag, ".xu"}, {31'd0, ifc.xu}, {31'd0, eu});
        chk({tag, ".ao"}, {31'd0, ifc.ao}, {31'd0, ea});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        ifc.en   = 1'b0;
        ifc.n    = 1'b0;
        ifc.x    = 32'h0;

        // Reset with en high and live data: reset wins
        tick(1'b1, 1'b1, 32'h3F80_0000);
        tick(1'b1, 1'b1, 32'h3F80_0000);
        chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Single sample
        put(1'b1, 32'h3F80_0000);
        idle(); idle(); idle();
        chk_out("single", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream: 1.0, +1.0, -0.5
        put(1'b1, 32'h3F80_0000);
        put(1'b0, 32'h3F80_0000);
        put(1'b0, 32'hBF00_0000);
        idle(); chk_out("b2b0", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("b2b1", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("b2b2", 32'h3FC0_0000, 1'b0, 1'b0, 1'b0);

        // Restart with 2.5 and stall mid-pipeline with junk on the inputs
        put(1'b1, 32'h4020_0000);
        idle();
        tick(1'b0, 1'b1, 32'h4100_0000);
        tick(1'b0, 1'b1, 32'h4100_0000);
        chk_out("stall_mid", 32'h3FC0_0000, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 32'h4100_0000);
        tick(1'b0, 1'b1, 32'h4100_0000);
        tick(1'b0, 1'b1, 32'h4100_0000);
        chk_out("stall_end", 32'h3FC0_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("resume0", 32'h3FC0_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("restart", 32'h4020_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("hold", 32'h4020_0000, 1'b0, 1'b0, 1'b0);

        // Input range flags around a base of 1.0
        put(1'b1, 32'h3F80_0000);     // A: 1.0
        put(1'b0, 32'h5380_0000);     // B: 2^40 overflow
        put(1'b0, 32'h2B80_0000);     // C: 2^-40 underflow
        put(1'b0, 32'h7FC0_0000);     // D: NaN
        chk_out("flagA", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        put(1'b0, 32'h4F80_0000);     // E: exactly 2^32, overflow
        chk_out("big", 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        put(1'b0, 32'h0000_0001);     // F: denormal
        chk_out("tiny", 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
        put(1'b0, 32'h8000_0000);     // G: -0
        chk_out("nan", 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        put(1'b0, 32'h3080_0000);     // H: exactly 2^-30, one LSB, truncated in output
        chk_out("two32", 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        idle(); chk_out("denorm", 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
        idle(); chk_out("negzero", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("lsb", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);

        // Accumulator overflow: four samples of 2^31 reach 2^33 and wrap to -2^33
        put(1'b1, 32'h4F00_0000);
        put(1'b0, 32'h4F00_0000);
        put(1'b0, 32'h4F00_0000);
        put(1'b0, 32'h4F00_0000);
        chk_out("ov1", 32'h4F00_0000, 1'b0, 1'b0, 1'b0);
        idle();
        chk_out("ov2", 32'h4F80_0000, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h3F80_0000);
        chk_out("ov3", 32'h4FC0_0000, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("ov4", 32'hD000_0000, 1'b0, 1'b0, 1'b1);
        idle(); chk_out("ov_sticky", 32'hD000_0000, 1'b0, 1'b0, 1'b1);
        idle(); chk_out("ov_clear", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);

        // Reset with two samples in flight, en low during the reset edge
        put(1'b1, 32'h4000_0000);
        put(1'b0, 32'h5380_0000);
        reset_n = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        chk_out("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        idle(); chk_out("rst_f1", 32'h0, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("rst_f2", 32'h0, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("rst_f3", 32'h0, 1'b0, 1'b0, 1'b0);
        idle(); chk_out("rst_f4", 32'h0, 1'b0, 1'b0, 1'b0);

        // Continuing without n after reset adds onto a cleared accumulator
        put(1'b0, 32'h3F80_0000);
        idle(); idle(); idle();
        chk_out("post_rst", 32'h3F80_0000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Pipelined IEEE-754 single-precision accumulator that sums a stream of float samples into a wide internal fixed-point register and returns the running sum as a float. It sits after the `term` evaluation pipeline in the Avalon peripheral. The wrapper steers `en` and `n` so that a new accumulation starts on demand and the result is read 4 enabled cycles after the last sample.

## Interface
- `LATENCY`, 4: enabled clock edges from sample to matching `r`. Fixed; not overridable.
- `ACC_W`, 64: internal two's-complement accumulator width. LSB weight 2^-30; representable magnitude < 2^33.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low; clock clk.
- `en` in 1: clock enable. When 0, every register (pipeline and accumulator) holds.
- `x` in 32: float sample.
- `n` in 1: new-accumulation flag, qualified by `en`, sampled with `x`.
- `r` out 32: float running sum.
- `xo` out 1: input overflow for the sample aligned with `r`.
- `xu` out 1: input underflow for the sample aligned with `r`.
- `ao` out 1: accumulator overflow, sticky within an accumulation.

## Operation
- **S1 align:** unpack `x` and shift its mantissa to the fixed-point grid (LSB 2^-30); negate if the sign is set.
  - exp = 255 (Inf/NaN), or |x| ≥ 2^32: `xo` = 1; contributes 0.
  - Nonzero |x| < 2^-30, or denormal: `xu` = 1; contributes 0.
  - Bits below 2^-30 are truncated.
  - ±0 contributes 0 and sets no flag.
- **S2 accumulate:** `acc` = n ? aligned : acc + aligned.
  - If a signed add overflows 64 bits, `acc` wraps and `ao` is set.
  - `ao` stays set until a sample with n = 1 passes S2; that sample's own overflow state then applies.
- **S3:** take the magnitude of `acc` and count its leading zeros.
- **S4 normalize:**
  - Shift left by the leading-zero count.
  - Mantissa = top 24 bits, truncated toward zero.
  - Exponent = 127 + (position of the leading one − 30).
  - `acc` = 0 gives `r` = 0x00000000.
- Flags travel with their sample, so `xo`/`xu`/`ao` stay aligned with `r`.
- Throughput: one sample per enabled cycle. Back-to-back samples accumulate correctly because the loop-carried path is a single-cycle integer add.

## Timing
- Reset:
  - While `reset_n` = 0 at a rising edge, all registers clear: `r` = 0, `xo` = `xu` = `ao` = 0, `acc` = 0.
  - Reset overrides `en`.
  - Reset mid-accumulation discards the partial sum.
- A sample accepted at enabled edge k appears on `r` and the flags after enabled edge k+3. It is stable from then until the next enabled edge (4-stage pipeline, `LATENCY` = 4 counting the capture edge).
- Edges with `en` = 0 are not counted and change no output.
- `n` and `x` apply only at edges with `en` = 1.
- While `en` = 1 with no new sample, the wrapper drives x = 0, n = 0 (adds zero, preserves the sum).
- Simultaneous n = 1 and overflow-class input: `acc` = 0, `xo`/`xu` set, `ao` cleared.

## Structure
- Shared package `fp_acc_pkg`:
  - `ACC_W`, `LSB_EXP` (−30), `MAX_EXP` (32), `FP_BIAS` (127).
  - Float field typedef (sign / exponent[7:0] / mantissa[22:0]).
- One natural sub-module: `fp_acc_lzc`, a 64-bit leading-zero counter used in S3.
- `term` is a separate upstream block: 6-enabled-cycle float pipeline with ports `clk`, `clk_en`, `reset`, `x`, `result`. It is not part of this block.

## Test plan
- **Single sample:** n = 1, x = 0x3F800000 (1.0), `en` held for 4 edges → `r` = 0x3F800000, all flags 0.
- **Back-to-back stream:**
  - Input: n = 1 with 1.0, then n = 0 with 1.0, then n = 0 with 0xBF000000 (−0.5), on consecutive enabled edges.
  - Response: `r` = 0x3F800000, 0x40000000, 0x3FC00000 on three consecutive cycles from latency.
- **Restart and stall:**
  - Following from the previous scenario, n = 1 with 0x40200000 (2.5) → `r` = 0x40200000; the prior sum is discarded.
  - Drop `en` for 5 cycles mid-pipeline → `r` frozen; the result emerges after the remaining enabled edges.
- **Input range flags:**
  - x = 0x53800000 (2^40) → `xo` = 1, sum unchanged.
  - x = 0x2B800000 (2^-40) → `xu` = 1, sum unchanged.
  - x = 0x7FC00000 (NaN) → `xo` = 1.
- **Accumulator overflow:** n = 1 with 0x4F000000 (2^31), then three more 2^31 samples (total 2^33) → `ao` = 1 on the 4th result. `ao` stays 1 until an n = 1 sample, then returns to 0.
- **Reset mid-operation:** `reset_n` = 0 for 1 edge with 2 samples in flight → `r` = 0 and all flags 0 next cycle. No stale result emerges later.
